// File: rtl/axi4s_pattern_gen_pkg.sv
// Shared types and constants for the AXI4-Stream pattern generator and its
// next-value function.
package axi4s_pattern_gen_pkg;

    typedef enum logic [1:0] {
        MODE_INCR  = 2'd0,
        MODE_LFSR  = 2'd1,
        MODE_WALK1 = 2'd2,
        MODE_CONST = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    localparam logic [31:0] LFSR_POLY_DEFAULT = 32'h8020_0003;

    // A zero register is a fixed point for LFSR and WALK1, so those modes
    // must never start from zero.
    function automatic logic needs_nonzero_seed(input mode_e m);
        return (m == MODE_LFSR) || (m == MODE_WALK1);
    endfunction

endpackage

// File: rtl/axi4s_pattern_next.sv
// Combinational next-value function for the pattern generator; also used by
// the matching stream checker so both sides agree on the sequence.
module axi4s_pattern_next
    import axi4s_pattern_gen_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          INC       = 1,
    parameter logic [31:0] LFSR_POLY = LFSR_POLY_DEFAULT
) (
    input  mode_e             mode_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] nxt_o
);

    // Only the low DATA_W bits of the tap mask apply; zero-extend for wide buses.
    localparam logic [63:0]       POLY_EXT = {32'd0, LFSR_POLY};
    localparam logic [DATA_W-1:0] POLY_V   = POLY_EXT[DATA_W-1:0];
    localparam logic [DATA_W-1:0] INC_V    = DATA_W'(INC);

    always_comb begin
        nxt_o = d_i;
        case (mode_i)
            MODE_INCR:  nxt_o = d_i + INC_V;
            MODE_LFSR:  nxt_o = d_i[0] ? ((d_i >> 1) ^ POLY_V) : (d_i >> 1);
            MODE_WALK1: nxt_o = {d_i[DATA_W-2:0], d_i[DATA_W-1]};
            default:    nxt_o = d_i;
        endcase
    end

endmodule

// File: rtl/axi4s_pattern_gen.sv
// AXI4-Stream packetised test-pattern source with packet counter.
// Optional one-shot TDATA[0] error injection: define AXI4S_PATTERN_GEN_ERR_INJ_EN.
module axi4s_pattern_gen
    import axi4s_pattern_gen_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          PKT_LEN_W = 16,
    parameter int          INC       = 1,
    parameter logic [31:0] LFSR_POLY = LFSR_POLY_DEFAULT
) (
    input  logic                 ACLK,
    input  logic                 RSTN,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [DATA_W-1:0]    seed,
    input  logic [PKT_LEN_W-1:0] pkt_len,
`ifdef AXI4S_PATTERN_GEN_ERR_INJ_EN
    input  logic                 err_inj,
`endif
    output logic [DATA_W-1:0]    TDATA,
    output logic                 TVALID,
    input  logic                 TREADY,
    output logic                 TLAST,
    output logic [31:0]          pkt_cnt,
    output logic                 busy
);

    state_e                 state_q;
    mode_e                  mode_q;
    logic [DATA_W-1:0]      data_q;
    logic [DATA_W-1:0]      tdata_q;
    logic [PKT_LEN_W-1:0]   beat_q;
    logic [PKT_LEN_W-1:0]   len_m1_q;
    logic                   tvalid_q;
    logic                   tlast_q;
    logic [31:0]            pkt_cnt_q;
    logic                   busy_q;

    mode_e                  mode_in;
    logic [PKT_LEN_W-1:0]   len_m1_d;
    logic [PKT_LEN_W-1:0]   beat_inc_d;
    logic [DATA_W-1:0]      seed_d;
    logic [DATA_W-1:0]      nxt_d;
    logic [DATA_W-1:0]      flip_vec;
    logic                   flip_d;
    logic                   hs;
    logic                   last_hs;

    assign mode_in    = mode_e'(mode);
    assign len_m1_d   = (pkt_len == '0) ? '0 : pkt_len - PKT_LEN_W'(1);
    assign beat_inc_d = beat_q + PKT_LEN_W'(1);
    assign seed_d     = (needs_nonzero_seed(mode_in) && (seed == '0)) ? DATA_W'(1) : seed;
    assign hs         = tvalid_q & TREADY;
    assign last_hs    = hs & tlast_q;

    axi4s_pattern_next #(
        .DATA_W    (DATA_W),
        .INC       (INC),
        .LFSR_POLY (LFSR_POLY)
    ) u_next (
        .mode_i (mode_q),
        .d_i    (data_q),
        .nxt_o  (nxt_d)
    );

`ifdef AXI4S_PATTERN_GEN_ERR_INJ_EN
    // arm_q: an injection is pending; flip_q: the beat now on the bus is the
    // corrupted one. A pulse on a load edge corrupts the beat being loaded,
    // never the one already presented, so TDATA stays stable under stall.
    logic arm_q;
    logic flip_q;
    logic clear_arm;
    logic load;

    assign clear_arm = hs & flip_q;
    assign flip_d    = arm_q ? ~clear_arm : err_inj;
    assign load      = hs | ((state_q == ST_IDLE) & en);

    always_ff @(posedge ACLK or negedge RSTN) begin
        if (!RSTN) begin
            arm_q  <= 1'b0;
            flip_q <= 1'b0;
        end else begin
            arm_q <= flip_d;
            if (load) begin
                flip_q <= flip_d;
            end
        end
    end
`else
    assign flip_d = 1'b0;
`endif

    assign flip_vec = {{(DATA_W-1){1'b0}}, flip_d};

    always_ff @(posedge ACLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_INCR;
            data_q    <= '0;
            tdata_q   <= '0;
            beat_q    <= '0;
            len_m1_q  <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            pkt_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_q  <= ST_ACTIVE;
                        mode_q   <= mode_in;
                        data_q   <= seed_d;
                        tdata_q  <= seed_d ^ flip_vec;
                        beat_q   <= '0;
                        len_m1_q <= len_m1_d;
                        tvalid_q <= 1'b1;
                        tlast_q  <= (len_m1_d == '0);
                        busy_q   <= 1'b1;
                    end
                end
                default: begin
                    // ACTIVE and FINISH share the beat datapath; only the
                    // decision at the packet boundary differs.
                    if (hs) begin
                        data_q  <= nxt_d;
                        tdata_q <= nxt_d ^ flip_vec;
                    end
                    if (last_hs) begin
                        pkt_cnt_q <= pkt_cnt_q + 32'd1;
                        beat_q    <= '0;
                        if ((state_q == ST_ACTIVE) && en) begin
                            mode_q   <= mode_in;
                            len_m1_q <= len_m1_d;
                            tlast_q  <= (len_m1_d == '0);
                        end else begin
                            state_q  <= ST_IDLE;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            busy_q   <= 1'b0;
                        end
                    end else begin
                        if (hs) begin
                            beat_q  <= beat_inc_d;
                            tlast_q <= (beat_inc_d == len_m1_q);
                        end
                        if (!en) begin
                            state_q <= ST_FINISH;
                        end
                    end
                end
            endcase
        end
    end

    assign TDATA   = tdata_q;
    assign TVALID  = tvalid_q;
    assign TLAST   = tlast_q;
    assign pkt_cnt = pkt_cnt_q;
    assign busy    = busy_q;

endmodule

// File: doc/axi4s_pattern_gen.md
Name: axi4s_pattern_gen

Overview:
- Parametrised AXI4-Stream test-pattern source for fabric bring-up and DMA loopback tests on PolarFire SoC.
- Generates packetised data on a full TVALID/TREADY handshake with TLAST, in one of four run-time-selectable patterns.
- Drives a stream sink such as an AXI4-Stream FIFO or DMA S2MM port.
- Counts completed packets for software status readback.

Parameters:
- DATA_W, 32, TDATA width in bits; 8 to 64 inclusive.
- PKT_LEN_W, 16, width of the pkt_len beat-count input.
- INC, 1, increment step for INCR mode, applied modulo 2^DATA_W.
- LFSR_POLY, 32'h8020_0003, Galois feedback taps for LFSR mode; only the low DATA_W bits are used.

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- RSTN  in  1  asynchronous active-low reset.
- en  in  1  run enable; level-sensitive.
- mode  in  2  pattern select: 0 INCR, 1 LFSR, 2 WALK1, 3 CONST.
- seed  in  DATA_W  first TDATA value after leaving IDLE.
- pkt_len  in  PKT_LEN_W  beats per packet; 0 is treated as 1.
- TDATA  out  DATA_W  stream data.
- TVALID  out  1  stream valid.
- TREADY  in  1  stream ready.
- TLAST  out  1  last beat of a packet.
- pkt_cnt  out  32  number of completed packets; wraps modulo 2^32.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: all outputs go to 0 and the FSM goes to IDLE.
  - Reset asserted mid-packet aborts the packet immediately.
  - TVALID drops asynchronously with reset; this is the only permitted TVALID drop without a handshake.
- All outputs are registered.
- FSM states: IDLE, ACTIVE, FINISH.
  - IDLE: TVALID=0. If en=1, in the same edge: load the data register with the normalised seed, clear the beat counter, latch mode and pkt_len, go to ACTIVE. TVALID=1 from the next cycle, so latency is 1 cycle from en high to the first beat.
  - ACTIVE: TVALID=1. A handshake is TVALID&TREADY. On each handshake, the data register takes the next pattern value and the beat counter increments.
  - TLAST=1 exactly while beat counter == latched pkt_len-1.
  - Handshake on the TLAST beat: pkt_cnt increments and the beat counter clears. If en=1, latch mode and pkt_len again and stay in ACTIVE. The data sequence continues and is not reloaded from seed. If en=0, go to IDLE with TVALID=0 next cycle.
  - en falling mid-packet: go to FINISH. The packet still completes in full; en is never a packet abort.
  - FINISH: behaves as ACTIVE but ignores en. After the TLAST handshake, go to IDLE.
- AXI4-Stream rules:
  - Once asserted, TVALID stays high until a handshake.
  - TDATA and TLAST are stable while TVALID=1 and TREADY=0.
  - TVALID never depends combinationally on TREADY.
- mode and pkt_len changes take effect only at a packet boundary.
- Pattern next-value rules:
  - INCR: d + INC, truncated to DATA_W bits, wraps.
  - LFSR: Galois right shift. If d[0]=1, next = (d>>1) ^ LFSR_POLY, else next = d>>1.
  - WALK1: rotate d left by 1.
  - CONST: next = d.
- Seed normalisation: a zero seed in LFSR or WALK1 mode is replaced by 1, avoiding the lock-up state.
- pkt_len = 0 and pkt_len = 1 are identical: every beat carries TLAST.
- pkt_cnt does not clear on en; only reset clears it.
- busy = (state != IDLE).

Optional Feature:
- Macro AXI4S_PATTERN_GEN_ERR_INJ_EN.
- When defined:
  - Adds input port err_inj (1 bit).
  - A single-cycle pulse arms a one-shot flag.
  - The next beat to complete a handshake has TDATA[0] inverted on the wire. The internal pattern register is not corrupted, so following beats are correct.
  - The flag clears on that handshake. Pulses arriving while the flag is armed are ignored.
  - The arm is held while in IDLE.
  - If the arm coincides with a beat already presented on the bus, the inversion applies to the next beat, so TDATA stays stable while TVALID is high.
- When undefined: no port is added and the logic is identical to the feature-off behaviour.

Decomposition:
- Package axi4s_pattern_gen_pkg holds:
  - mode enum (MODE_INCR, MODE_LFSR, MODE_WALK1, MODE_CONST);
  - FSM state enum;
  - default LFSR_POLY constant.
- Sub-module axi4s_pattern_next: purely combinational next-value function of (mode, d). It is shared with the checker in the matching stream checker block.

Test Plan:
- INCR, seed=0, pkt_len=4, TREADY=1, en held → TDATA 0,1,2,3 with TLAST on 3; continues 4..7; pkt_cnt=2 after 8 beats.
- TREADY toggling 1010…, seed=32'hFFFF_FFFE → TDATA/TVALID stable while stalled; wrap FFFF_FFFE, FFFF_FFFF, 0000_0000.
- LFSR, seed=0 → first beat 1, second beat 32'h8020_0003 (d[0]=1 applies the taps); no zero value across 1000 beats.
- en dropped after beat 1 of pkt_len=8 → beats 2..7 still sent, TLAST on beat 7, then TVALID=0 and busy=0.
- RSTN pulled low mid-packet with TREADY=0 → TVALID, TLAST, pkt_cnt, busy all 0 immediately; restart begins from seed.
- pkt_len=0, WALK1, seed=32'h8000_0000 → every beat has TLAST; TDATA 8000_0000, 0000_0001, 0000_0002; with ERR_INJ_EN, a pulse inverts only the next beat's bit 0.
